// File: rtl/phase_gen_pkg.sv
// Shared definitions for the multi-phase generator: step sizes, index clamp
// and slip-counter saturation limits.
package phase_gen_pkg;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_NORM = 2'd1,
    STEP_SKIP = 2'd2
  } step_e;

  // Out-of-range load indices collapse onto the last phase.
  function automatic int unsigned clamp_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (n - 1) : idx;
  endfunction

  function automatic int sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/phase_generator_n_if.sv
// Control/status bundle between the phase detector side and the generator.
interface phase_generator_n_if #(
  parameter int unsigned NUM_PHASES = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_PHASES),
  parameter int unsigned SLIP_W     = 8
);
  logic                     en;
  logic                     up;
  logic                     dn;
  logic                     load;
  logic [IDX_W-1:0]         load_idx;
  logic [NUM_PHASES-1:0]    phase_out;
  logic [IDX_W-1:0]         phase_idx;
  logic                     wrap;
  logic signed [SLIP_W-1:0] slip_cnt;

  modport master (
    output en, up, dn, load, load_idx,
    input  phase_out, phase_idx, wrap, slip_cnt
  );

  modport slave (
    input  en, up, dn, load, load_idx,
    output phase_out, phase_idx, wrap, slip_cnt
  );
endinterface

// File: rtl/sat_updown_counter.sv
// Signed up/down counter that sticks at its limits, with synchronous clear.
module sat_updown_counter
  import phase_gen_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  input  logic                dec,
  output logic signed [W-1:0] cnt
);
  localparam logic signed [W-1:0] CNT_MAX = W'(sat_max(W));
  localparam logic signed [W-1:0] CNT_MIN = W'(sat_min(W));
  localparam logic signed [W-1:0] CNT_ONE = W'(1);

  logic signed [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, simultaneous inc/dec cancel, limits are sticky.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec && !inc && (cnt_q != CNT_MIN)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/phase_generator_n.sv
// Parametrised one-hot phase rotator with skip/hold corrections, wrap strobe
// and saturating slip count.
module phase_generator_n
  import phase_gen_pkg::*;
#(
  parameter int unsigned NUM_PHASES = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_PHASES),
  parameter int unsigned SLIP_W     = 8
) (
  input logic               clk,
  input logic               rst,
  phase_generator_n_if.slave bus
);
  localparam logic [IDX_W:0] SUM_N = (IDX_W + 1)'(NUM_PHASES);

  step_e                 step;
  logic [IDX_W:0]        sum;
  logic                  wrap_hit;
  logic [IDX_W-1:0]      idx_next;
  logic [IDX_W-1:0]      idx_ld;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_PHASES-1:0] out_q, out_d;
  logic                  slip_inc, slip_dec;
  logic signed [SLIP_W-1:0] slip_cnt;

  // Step selection and modular add; a single conditional subtract suffices
  // because the step never exceeds 2 and NUM_PHASES is at least 3.
  always_comb begin
    unique case ({bus.up, bus.dn})
      2'b10:   step = STEP_SKIP;
      2'b01:   step = STEP_HOLD;
      default: step = STEP_NORM;
    endcase
    sum      = {1'b0, idx_q} + {{(IDX_W - 1){1'b0}}, step};
    wrap_hit = (sum >= SUM_N);
    idx_next = wrap_hit ? IDX_W'(sum - SUM_N) : sum[IDX_W-1:0];
    idx_ld   = IDX_W'(clamp_idx(32'(bus.load_idx), NUM_PHASES));
  end

  // Next-state: load beats enable; disabled cycles hold and drop the strobe.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      idx_d = idx_ld;
    end else if (bus.en) begin
      idx_d  = idx_next;
      wrap_d = wrap_hit;
    end
    out_d = NUM_PHASES'(1) << idx_d;
  end

  // Slip counter strobes: only uncancelled corrections on effective steps.
  always_comb begin
    slip_inc = bus.en && !bus.load && bus.up && !bus.dn;
    slip_dec = bus.en && !bus.load && bus.dn && !bus.up;
  end

  // Index, strobe and decoded phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
      out_q  <= NUM_PHASES'(1);
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      out_q  <= out_d;
    end
  end

  sat_updown_counter #(
    .W (SLIP_W)
  ) u_slip (
    .clk (clk),
    .rst (rst),
    .clr (bus.load),
    .inc (slip_inc),
    .dec (slip_dec),
    .cnt (slip_cnt)
  );

  assign bus.phase_idx = idx_q;
  assign bus.wrap      = wrap_q;
  assign bus.phase_out = out_q;
  assign bus.slip_cnt  = slip_cnt;
endmodule

// File: tb/tb_phase_generator_n.sv
// Directed bench for phase_generator_n: a 16-phase instance with a 4-bit slip
// counter and a 5-phase instance with the default slip width.
module tb_phase_generator_n;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  phase_generator_n_if #(.NUM_PHASES(16), .SLIP_W(4)) bus16 ();
  phase_generator_n_if #(.NUM_PHASES(5))              bus5 ();

  phase_generator_n #(.NUM_PHASES(16), .SLIP_W(4)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  phase_generator_n #(.NUM_PHASES(5)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk16(input string tag, input int unsigned idx, input bit w, input int s);
    check({tag, " idx16"},  bus16.phase_idx, idx);
    check({tag, " out16"},  bus16.phase_out, 64'(1) << idx);
    check({tag, " wrap16"}, bus16.wrap, w);
    check({tag, " slip16"}, bus16.slip_cnt, s);
  endtask

  task automatic chk5(input string tag, input int unsigned idx, input bit w, input int s);
    check({tag, " idx5"},  bus5.phase_idx, idx);
    check({tag, " out5"},  bus5.phase_out, 64'(1) << idx);
    check({tag, " wrap5"}, bus5.wrap, w);
    check({tag, " slip5"}, bus5.slip_cnt, s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned e;
    int unsigned sum;
    int          s;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus16.en = 0; bus16.up = 0; bus16.dn = 0; bus16.load = 0; bus16.load_idx = '0;
    bus5.en  = 0; bus5.up  = 0; bus5.dn  = 0; bus5.load  = 0; bus5.load_idx  = '0;

    #1 rst = 1'b1;
    #2;
    chk16("reset", 0, 0, 0);
    chk5("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus16.en = 1'b1;

    // Free run: wrap only on the 15 -> 0 edge.
    e = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      e = (e + 1) % 16;
      chk16("run", e, e == 0, 0);
    end

    // Hold three cycles with dn at idx 7.
    bus16.load = 1; bus16.load_idx = 4'd7;
    tick();
    chk16("ld7", 7, 0, 0);
    bus16.load = 0; bus16.dn = 1;
    tick(); chk16("dn1", 7, 0, -1);
    tick(); chk16("dn2", 7, 0, -2);
    tick(); chk16("dn3", 7, 0, -3);
    bus16.dn = 0;
    tick(); chk16("resume", 8, 0, -3);

    // Saturation of the 4-bit slip counter.
    bus16.load = 1; bus16.load_idx = 4'd0;
    tick(); chk16("ld0", 0, 0, 0);
    bus16.load = 0; bus16.up = 1;
    e = 0; s = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      s = (s < 7) ? s + 1 : 7;
      sum = e + 2;
      e = sum % 16;
      chk16("upsat", e, sum >= 16, s);
    end
    bus16.up = 0; bus16.dn = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      s = (s > -8) ? s - 1 : -8;
      chk16("dnsat", 4, 0, s);
    end
    bus16.up = 1;
    tick(); chk16("both", 5, 0, -8);

    // Load has priority over up and clears the slip count.
    bus16.dn = 0; bus16.load = 1; bus16.load_idx = 4'd15;
    tick(); chk16("ld15", 15, 0, 0);
    bus16.load = 0; bus16.up = 0;
    tick(); chk16("wrapn", 0, 1, 0);
    bus16.en = 0;
    tick(); chk16("enoff", 0, 0, 0);

    // Asynchronous reset mid-cycle.
    bus16.en = 1; bus16.load = 1; bus16.load_idx = 4'd9;
    tick(); chk16("ld9", 9, 0, 0);
    bus16.load = 0;
    #1 rst = 1'b1;
    #1 chk16("arst", 0, 0, 0);
    #1 rst = 1'b0;
    tick(); chk16("postrst", 1, 0, 0);
    bus16.en = 0; bus16.up = 1;
    tick(); chk16("hold1", 1, 0, 0);
    tick(); chk16("hold2", 1, 0, 0);
    bus16.up = 0;

    // Five-phase instance: skip across the wrap point and index clamping.
    bus5.en = 1; bus5.load = 1; bus5.load_idx = 3'd3;
    tick(); chk5("ld3", 3, 0, 0);
    bus5.load = 0; bus5.up = 1;
    tick(); chk5("skip3", 0, 1, 1);
    bus5.up = 0;
    tick(); chk5("n1", 1, 0, 1);
    tick(); chk5("n2", 2, 0, 1);
    tick(); chk5("n3", 3, 0, 1);
    tick(); chk5("n4", 4, 0, 1);
    bus5.up = 1;
    tick(); chk5("skip4", 1, 1, 2);
    bus5.up = 0;
    tick(); chk5("m2", 2, 0, 2);
    tick(); chk5("m3", 3, 0, 2);
    tick(); chk5("m4", 4, 0, 2);
    tick(); chk5("m0", 0, 1, 2);
    bus5.dn = 1;
    tick(); chk5("dn0", 0, 0, 1);
    bus5.dn = 0; bus5.load = 1; bus5.load_idx = 3'd6;
    tick(); chk5("clamp6", 4, 0, 0);
    bus5.load_idx = 3'd7;
    tick(); chk5("clamp7", 4, 0, 0);
    bus5.load = 0;
    tick(); chk5("post", 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
